// File: rtl/param_tagged_fifo.sv
// param_tagged_fifo: synchronous first-word-fall-through FIFO carrying a data
// payload together with an ID tag, with occupancy and drop counters.
//
// Build option: define PARAM_FIFO_ID_FILTER_EN to compile in ID filtering.
// Accepted words whose tag equals FILTER_ID are then consumed but not stored,
// and drop_cnt counts them (saturating). Without the macro every accepted word
// is stored and drop_cnt is tied to zero. The port list is the same either way.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. ready never depends on valid from the same side, and in_ready /
// out_valid are decoded from registered occupancy only, so there is no
// combinational path from out_ready to in_ready. A producer holds its word
// stable until it is accepted; signals under a low valid are ignored.
module param_tagged_fifo #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ID_WIDTH   = 8,
  parameter int                  DEPTH      = 8,
  parameter logic [ID_WIDTH-1:0] FILTER_ID  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [ID_WIDTH-1:0]         in_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [$clog2(DEPTH):0]      count,
  output logic [15:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // Storage is never reset; only the pointers and occupancy define validity.
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;

  logic push;   // handshake on the input side
  logic pop;    // handshake on the output side
  logic drop;   // accepted word that is discarded by the filter
  logic store;  // accepted word that is written into the array

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef PARAM_FIFO_ID_FILTER_EN
  assign drop = push && (in_id == FILTER_ID);
`else
  assign drop = 1'b0;
`endif

  assign store = push && !drop;

  // Head entry is presented directly from the array (fall-through read).
  assign out_id   = mem[rd_ptr].id;
  assign out_data = mem[rd_ptr].data;
  assign count    = count_q;

  // Array write: contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{id: in_id, data: in_data};
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({store, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef PARAM_FIFO_ID_FILTER_EN
  logic [15:0] drop_q;

  // Filtered-word counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_param_tagged_fifo.sv
// Self-checking bench for param_tagged_fifo (DATA_WIDTH=8, ID_WIDTH=4,
// DEPTH=8, FILTER_ID=5). Honours PARAM_FIFO_ID_FILTER_EN the same way as the
// design so the filter expectations match the build.
module tb_param_tagged_fifo;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int W  = DW + IW;

`ifdef PARAM_FIFO_ID_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_id;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic [3:0]    count;
  logic [15:0]   drop_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_tagged_fifo #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .DEPTH      (8),
    .FILTER_ID  (4'd5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int           m_cnt;
  int           m_drop;
  int           errors;
  int           checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply reset for one cycle (possibly mid-transfer) and clear the model.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_cnt  = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle of stimulus ----------------
  // Inputs are driven just after a rising edge, outputs are checked on the
  // falling edge against the model, and the model is advanced for the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [IW-1:0] id,
                      input logic ordy);
    logic         acc;
    logic         pop;
    logic         drop_it;
    logic [W-1:0] exp;
    in_valid  = iv;
    in_data   = d;
    in_id     = id;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready",  {31'd0, in_ready},  {31'd0, (m_cnt != 8)});
    check("out_valid", {31'd0, out_valid}, {31'd0, (m_cnt != 0)});
    check("count",     {28'd0, count},     m_cnt);
    check("drop_cnt",  {16'd0, drop_cnt},  m_drop);
    pop     = (m_cnt != 0) && ordy;
    acc     = iv && (m_cnt != 8);
    drop_it = acc && FILTER_ON && (id == 4'd5);
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pop expected none (t=%0t)", $time);
      end else begin
        exp = exp_q.pop_front();
        check("head", {20'd0, out_id, out_data}, {20'd0, exp});
      end
    end
    if (acc && !drop_it) exp_q.push_back({id, d});
    if (drop_it && m_drop != 16'hFFFF) m_drop++;
    m_cnt = m_cnt + ((acc && !drop_it) ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic          ordy;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    errors    = 0;
    checks    = 0;
    m_cnt     = 0;
    m_drop    = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_id     = '0;
    out_ready = 1'b0;
    rst       = 1'b1;

    vecs[0] = '{1'b1, 8'd2, 4'd1, 1'b0, 1};
    vecs[1] = '{1'b1, 8'd3, 4'd2, 1'b0, 2};
    vecs[2] = '{1'b1, 8'd6, 4'd3, 1'b0, 3};
    vecs[3] = '{1'b0, 8'd0, 4'd0, 1'b1, 2};
    vecs[4] = '{1'b0, 8'd0, 4'd0, 1'b1, 1};
    vecs[5] = '{1'b0, 8'd0, 4'd0, 1'b1, 0};

    // Reset then idle
    @(posedge clk);
    do_reset();
    step(1'b0, 8'd0, 4'd0, 1'b0);
    step(1'b0, 8'd0, 4'd0, 1'b0);

    // Reset mid-transfer with three entries held
    step(1'b1, 8'd11, 4'd1, 1'b0);
    step(1'b1, 8'd12, 4'd1, 1'b0);
    step(1'b1, 8'd13, 4'd1, 1'b0);
    check("pre_reset_count", {28'd0, count}, 3);
    do_reset();
    check("post_reset_count", {28'd0, count}, 0);
    check("post_reset_out_valid", {31'd0, out_valid}, 0);
    check("post_reset_in_ready", {31'd0, in_ready}, 1);
    step(1'b0, 8'd0, 4'd0, 1'b0);

    // Ordering and tags from the vector table
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        check("order_head_data", {24'd0, out_data}, 2);
        check("order_head_id", {28'd0, out_id}, 1);
      end
      step(vecs[i].iv, vecs[i].d, vecs[i].id, vecs[i].ordy);
      check("vec_count", {28'd0, count}, vecs[i].exp_cnt);
    end

    // Full and wrap-around
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 4'hA, 1'b0);
    check("full_count", {28'd0, count}, 8);
    check("full_in_ready", {31'd0, in_ready}, 0);
    step(1'b1, 8'd99, 4'hA, 1'b0);
    check("full_reject_count", {28'd0, count}, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 4'd0, 1'b1);
    check("after_pop3_count", {28'd0, count}, 5);
    for (int i = 8; i <= 10; i++) step(1'b1, 8'(i), 4'hA, 1'b0);
    check("refill_count", {28'd0, count}, 8);
    for (int v = 3; v <= 10; v++) begin
      check("wrap_data", {24'd0, out_data}, v);
      step(1'b0, 8'd0, 4'd0, 1'b1);
    end
    check("wrap_drained", {28'd0, count}, 0);

    // Simultaneous push and pop at count 4
    for (int i = 0; i < 4; i++) step(1'b1, 8'(20 + i), 4'h3, 1'b0);
    step(1'b1, 8'd24, 4'h3, 1'b1);
    check("simul4_count", {28'd0, count}, 4);
    for (int v = 21; v <= 24; v++) begin
      check("simul4_data", {24'd0, out_data}, v);
      step(1'b0, 8'd0, 4'd0, 1'b1);
    end

    // Simultaneous push and pop at full: pop only
    for (int i = 0; i < 8; i++) step(1'b1, 8'(40 + i), 4'h3, 1'b0);
    step(1'b1, 8'd77, 4'h3, 1'b1);
    check("simul8_count", {28'd0, count}, 7);
    for (int v = 41; v <= 47; v++) begin
      check("simul8_data", {24'd0, out_data}, v);
      step(1'b0, 8'd0, 4'd0, 1'b1);
    end
    check("simul8_drained", {28'd0, count}, 0);

    // Empty with push: not visible in the push cycle, visible the next
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_id     = 4'h7;
    out_ready = 1'b1;
    #2;
    check("empty_push_same_cycle", {31'd0, out_valid}, 0);
    step(1'b1, 8'h5A, 4'h7, 1'b1);
    check("empty_push_next_valid", {31'd0, out_valid}, 1);
    check("empty_push_next_data", {24'd0, out_data}, 32'h5A);
    check("empty_push_next_id", {28'd0, out_id}, 7);
    step(1'b0, 8'd0, 4'd0, 1'b1);

    // ID filtering (expectations follow the build option)
    step(1'b1, 8'd100, 4'd4, 1'b0);
    step(1'b1, 8'd101, 4'd5, 1'b0);
    step(1'b1, 8'd102, 4'd6, 1'b0);
    check("filter_count", {28'd0, count}, FILTER_ON ? 2 : 3);
    check("filter_drop_cnt", {16'd0, drop_cnt}, FILTER_ON ? 1 : 0);
    check("filter_head_id", {28'd0, out_id}, 4);
    step(1'b0, 8'd0, 4'd0, 1'b1);
    check("filter_second_id", {28'd0, out_id}, FILTER_ON ? 6 : 5);
    while (m_cnt != 0) step(1'b0, 8'd0, 4'd0, 1'b1);
    step(1'b0, 8'd0, 4'd0, 1'b0);
    check("sb_empty_at_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_tagged_fifo.md
# param_tagged_fifo

Parametrised synchronous FIFO that stores data words together with an ID tag and forwards them in order over valid/ready handshakes. It is the next generation of the parametrised data/ID block: data width, ID width and depth are all parameters, and it adds buffering, backpressure, occupancy reporting and optional ID filtering. It sits between any tagged producer and consumer in the generic model on a single clock.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: data payload width in bits (≥1).
- `ID_WIDTH`, default 8: tag width in bits (≥1).
- `DEPTH`, default 8: entry count; power of two, ≥2.
- `FILTER_ID`, default 0: tag value dropped when filtering is compiled in (`ID_WIDTH` bits).

Ports (`AW` = $clog2(`DEPTH`)):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers a word.
- `in_ready`  out  1  FIFO can accept a word.
- `in_data`  in  `DATA_WIDTH`  write payload.
- `in_id`  in  `ID_WIDTH`  write tag.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer takes the head entry.
- `out_data`  out  `DATA_WIDTH`  head payload.
- `out_id`  out  `ID_WIDTH`  head tag.
- `count`  out  `AW`+1  current occupancy, 0..`DEPTH`.
- `drop_cnt`  out  16  filtered-word counter; saturates at 16'hFFFF.

## Operation

- Push happens when `in_valid && in_ready`. Pop happens when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. `out_valid = (count != 0)`. Both are pure functions of registered state; there is no combinational path from `out_ready` to `in_ready`.
- Storage is a `DEPTH`-entry array of {id, data}, addressed by `wr_ptr`/`rd_ptr` (`AW` bits). Pointers wrap naturally from `DEPTH-1` to 0.
- `out_data`/`out_id` are read combinationally from `mem[rd_ptr]` (first-word fall-through). They are don't-care while `out_valid` is 0.
- `count` updates as follows: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Behaviour when full: `in_ready` is 0, so no push occurs even if a pop happens in the same cycle. `in_ready` rises the cycle after the pop.
- Behaviour when empty: a push is not visible at the output in the same cycle. `out_valid` rises the next cycle.
- Invalid-side signals are ignored when their valid is 0. Data under `in_valid` with `in_ready` low is not captured.
- Reset, including mid-transfer:
  - `wr_ptr`, `rd_ptr`, `count` and `drop_cnt` go to 0, so `out_valid` = 0 and `in_ready` = 1 in the cycle after reset is sampled.
  - Array contents are not cleared.
  - Any in-flight entries are discarded.

## Timing

- Latency from push to `out_valid` is 1 cycle.
- Throughput is one push and one pop per cycle.
- Reset output values: `in_ready` 1, `out_valid` 0, `count` 0, `drop_cnt` 0. `out_data`/`out_id` are undefined.
- `count` and `drop_cnt` are registered and reflect the current cycle's transfers on the next edge.

## Configuration

- Macro `PARAM_FIFO_ID_FILTER_EN`.
- Defined: a handshake with `in_id == FILTER_ID` is accepted (normal `in_ready` rules) but not written. `wr_ptr` and `count` stay unchanged, and `drop_cnt` increments, saturating at 16'hFFFF.
- Undefined: all accepted words are stored, and `drop_cnt` is tied to 0.
- Port list is identical in both builds.

## Test plan

- Reset then idle (`DEPTH`=8): `in_ready`=1, `out_valid`=0, `count`=0. Assert `rst` for 1 cycle while `count`=3: next cycle `count`=0, `out_valid`=0.
- Ordering and tags: push {data 2, id 1}, {3, 2}, {6, 3} with `out_ready`=0. Expect `count`=3. Then `out_ready`=1: outputs appear in order (2,1), (3,2), (6,3), and `count` returns to 0.
- Full and wrap-around: push 8 words 0..7, so `count`=8 and `in_ready`=0. A further push with value 99 is not stored. Pop 3 words, push 8..10: drained sequence is 3..10 across the pointer wrap.
- Simultaneous push and pop:
  - At `count`=4: `count` stays 4 and order is preserved.
  - At `count`=8 with `in_valid`=1: no push occurs and `count`=7 next cycle.
- Empty with push: push one word at `count`=0. `out_valid` is 0 in the push cycle and 1 the next cycle with the correct data.
- Filter (build with `PARAM_FIFO_ID_FILTER_EN`, `FILTER_ID`=5): push ids 4, 5, 6 → `count`=2, `drop_cnt`=1, outputs ids 4 then 6. Without the macro: `count`=3 and `drop_cnt`=0.
